// File: rtl/beat_sequencer.sv
// beat_sequencer: records timed key events into three slots and replays them onto the buzzer path.
// Optional build macro LOOP_PLAY_EN: playback restarts the slot until the play button is pressed again.
module beat_sequencer #(
  parameter int DEPTH    = 64,
  parameter int TICK_DIV = 50000,
  parameter int DUR_W    = 12
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [6:0] key_code,
  input  logic       rec_btn_n,
  input  logic       play_btn_n,
  input  logic [2:0] slot_sel,
  output logic [6:0] buzz_note,
  output logic [6:0] play_note,
  output logic       recording,
  output logic       playing,
  output logic [2:0] slot_valid,
  output logic       overflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW = 7 + DUR_W;

  typedef enum logic [2:0] {IDLE, REC, REC_FLUSH, PLAY_LOAD, PLAY_RUN} state_t;

  state_t           state;
  logic [2:0]       rec_sync, play_sync;
  logic             rec_press, play_press;
  logic             sel_ok;
  logic [1:0]       sel_idx, slot;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      slot_len [3];
  logic [6:0]       cur_note;
  logic [DUR_W-1:0] dur, countdown;
  logic             data_wait;
  logic             rec_evt, mem_we;
  logic [EW-1:0]    mem [3][DEPTH];
  logic [EW-1:0]    rd_data;

  // Buttons idle high; a press pulse fires one cycle after the synchronised falling edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rec_sync  <= 3'b111;
      play_sync <= 3'b111;
    end else begin
      rec_sync  <= {rec_sync[1:0], rec_btn_n};
      play_sync <= {play_sync[1:0], play_btn_n};
    end
  end

  assign rec_press  = rec_sync[2] & ~rec_sync[1];
  assign play_press = play_sync[2] & ~play_sync[1];
  assign tick       = (tick_cnt == TW'(TICK_DIV - 1));

  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    case (slot_sel)
      3'b001:  sel_idx = 2'd0;
      3'b010:  sel_idx = 2'd1;
      3'b100:  sel_idx = 2'd2;
      default: sel_ok  = 1'b0;
    endcase
  end

  // A note ends when the key changes or its duration would overflow the field.
  assign rec_evt = (state == REC) && !rec_press &&
                   ((key_code != cur_note) || (tick && (&dur)));
  assign mem_we  = rec_evt || (state == REC_FLUSH);

  always_ff @(posedge clock) begin
    if (mem_we)
      mem[slot][wr_ptr] <= {cur_note, dur};
    rd_data <= mem[slot][rd_ptr];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      slot       <= 2'd0;
      tick_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cur_note   <= 7'd0;
      dur        <= '0;
      countdown  <= '0;
      data_wait  <= 1'b0;
      for (int i = 0; i < 3; i++) slot_len[i] <= '0;
      slot_valid <= 3'b000;
      overflow   <= 1'b0;
      recording  <= 1'b0;
      playing    <= 1'b0;
      play_note  <= 7'd0;
      buzz_note  <= 7'd0;
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      buzz_note <= (key_code != 7'd0) ? key_code : play_note;
      case (state)
        IDLE: begin
          if (rec_press && sel_ok) begin
            state               <= REC;
            recording           <= 1'b1;
            slot                <= sel_idx;
            slot_valid[sel_idx] <= 1'b0;
            overflow            <= 1'b0;
            wr_ptr              <= '0;
            cur_note            <= key_code;
            dur                 <= '0;
            tick_cnt            <= '0;
          end else if (play_press && sel_ok && slot_valid[sel_idx]) begin
            state    <= PLAY_LOAD;
            playing  <= 1'b1;
            slot     <= sel_idx;
            rd_ptr   <= '0;
            tick_cnt <= '0;
          end
        end
        REC: begin
          if (rec_press) begin
            state <= REC_FLUSH;
          end else if (rec_evt) begin
            cur_note <= key_code;
            dur      <= '0;
            wr_ptr   <= wr_ptr + 1'b1;
            if (wr_ptr == AW'(DEPTH - 1)) begin
              overflow         <= 1'b1;
              slot_len[slot]   <= (AW + 1)'(DEPTH);
              slot_valid[slot] <= 1'b1;
              recording        <= 1'b0;
              state            <= IDLE;
            end
          end else if (tick) begin
            dur <= dur + 1'b1;
          end
        end
        REC_FLUSH: begin
          slot_len[slot]   <= {1'b0, wr_ptr} + 1'b1;
          slot_valid[slot] <= 1'b1;
          recording        <= 1'b0;
          state            <= IDLE;
        end
        PLAY_LOAD: begin
          if (play_press) begin
            state     <= IDLE;
            playing   <= 1'b0;
            play_note <= 7'd0;
          end else begin
            state     <= PLAY_RUN;
            data_wait <= 1'b1;
          end
        end
        PLAY_RUN: begin
          if (play_press) begin
            state     <= IDLE;
            playing   <= 1'b0;
            play_note <= 7'd0;
            data_wait <= 1'b0;
          end else if (data_wait) begin
            play_note <= rd_data[EW-1:DUR_W];
            countdown <= rd_data[DUR_W-1:0];
            data_wait <= 1'b0;
          end else if (countdown == '0) begin
            if (({1'b0, rd_ptr} + 1'b1) == slot_len[slot]) begin
`ifdef LOOP_PLAY_EN
              rd_ptr    <= '0;
              state     <= PLAY_LOAD;
              tick_cnt  <= '0;
`else
              state     <= IDLE;
              playing   <= 1'b0;
              play_note <= 7'd0;
`endif
            end else begin
              rd_ptr   <= rd_ptr + 1'b1;
              state    <= PLAY_LOAD;
              tick_cnt <= '0;
            end
          end else if (tick) begin
            countdown <= countdown - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: directed and randomized record/playback takes checked against an event-timeline model.
`timescale 1ns/1ps
module tb_beat_sequencer;
  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 4;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [6:0] key_code = 7'd0;
  logic       rec_btn_n = 1'b1;
  logic       play_btn_n = 1'b1;
  logic [2:0] slot_sel = 3'b001;
  logic [6:0] buzz_note, play_note;
  logic       recording, playing, overflow;
  logic [2:0] slot_valid;

  int checks = 0;
  int errors = 0;

  logic [6:0] ev_note [3][8];
  int         ev_dur  [3][8];
  int         ev_cnt  [3];
  logic [2:0] exp_valid;
  logic       exp_ovf;
  logic [6:0] take_note [8];
  int         take_dur  [8];
  int         take_n;

  beat_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) dut (
    .clock(clock), .resetn(resetn), .key_code(key_code),
    .rec_btn_n(rec_btn_n), .play_btn_n(play_btn_n), .slot_sel(slot_sel),
    .buzz_note(buzz_note), .play_note(play_note), .recording(recording),
    .playing(playing), .slot_valid(slot_valid), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Cycles one stored event occupies during playback: load, data, then dur ticks (at least one check cycle).
  function automatic int event_len(int d);
    return ((d * TICK_DIV > 2) ? d * TICK_DIV : 2) + 1;
  endfunction

  function automatic int take_length(int slot);
    int total = 0;
    for (int i = 0; i < ev_cnt[slot]; i++) total += event_len(ev_dur[slot][i]);
    return total;
  endfunction

  function automatic logic [6:0] exp_note(int slot, int p);
    int total, start, q;
    total = take_length(slot);
    if (p < 2 || total == 0) return 7'h00;
`ifdef LOOP_PLAY_EN
    q = ((p - 2) % total) + 2;
`else
    if (p >= total) return 7'h00;
    q = p;
`endif
    start = 0;
    for (int i = 0; i < ev_cnt[slot]; i++) begin
      if (q >= start + 2 && q <= start + event_len(ev_dur[slot][i]) + 1) return ev_note[slot][i];
      start += event_len(ev_dur[slot][i]);
    end
    return 7'h00;
  endfunction

  function automatic logic exp_playing(int slot, int p);
    bit looping;
`ifdef LOOP_PLAY_EN
    looping = 1'b1;
`else
    looping = 1'b0;
`endif
    return looping || (p < take_length(slot));
  endfunction

  // Returns on the negedge just before the clock edge that acts on the press.
  task automatic press_button(input bit play);
    @(negedge clock);
    if (play) play_btn_n = 1'b0; else rec_btn_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rec_btn_n  = 1'b1;
    play_btn_n = 1'b1;
  endtask

  task automatic record_take(input int slot);
    int cur, cum, writes, m;
    bit ovf;
    slot_sel = 3'(1 << slot);
    key_code = take_note[0];
    press_button(1'b0);
    cur = -1; cum = 0; writes = 0; ovf = 1'b0;
    for (int i = 1; i < take_n && !ovf; i++) begin
      cum += take_dur[i-1];
      repeat (TICK_DIV * cum + 1 - cur) @(negedge clock);
      cur = TICK_DIV * cum + 1;
      if (i == 1) begin
        check_output("rec_active", recording, 1);
        slot_sel = 3'b011;
      end
      key_code = take_note[i];
      writes++;
      if (writes == DEPTH) ovf = 1'b1;
    end
    if (!ovf) begin
      cum += take_dur[take_n-1];
      repeat (TICK_DIV * cum - 2 - cur) @(negedge clock);
      press_button(1'b0);
    end
    repeat (2) @(negedge clock);
    key_code = 7'd0;
    m = ovf ? DEPTH : take_n;
    ev_cnt[slot] = m;
    for (int i = 0; i < m; i++) begin
      ev_note[slot][i] = take_note[i];
      ev_dur[slot][i]  = take_dur[i];
    end
    exp_valid[slot] = 1'b1;
    exp_ovf = ovf;
    check_output("rec_done", recording, 0);
    check_output("overflow", overflow, exp_ovf);
    check_output("slot_valid", slot_valid, exp_valid);
    slot_sel = 3'(1 << slot);
  endtask

  task automatic play_take(input int slot, input int live_from, input int live_to);
    int window;
    logic [6:0] prev_key, prev_note, en;
    slot_sel = 3'(1 << slot);
    key_code = 7'd0;
    press_button(1'b1);
`ifdef LOOP_PLAY_EN
    window = 2 * take_length(slot) + 3;
`else
    window = take_length(slot) + 3;
`endif
    prev_key = 7'd0;
    prev_note = 7'd0;
    for (int p = 0; p < window; p++) begin
      @(negedge clock);
      en = exp_note(slot, p);
      check_output("play_note", play_note, en);
      check_output("playing", playing, exp_playing(slot, p));
      check_output("buzz_note", buzz_note, (prev_key != 7'd0) ? prev_key : prev_note);
      key_code  = (p >= live_from && p <= live_to) ? 7'h62 : 7'h00;
      prev_key  = key_code;
      prev_note = en;
    end
    key_code = 7'd0;
`ifdef LOOP_PLAY_EN
    press_button(1'b1);
    @(negedge clock);
    check_output("loop_stop_playing", playing, 0);
    check_output("loop_stop_note", play_note, 0);
`endif
  endtask

  task automatic random_take();
    logic [6:0] v;
    take_n = $urandom_range(1, 5);
    for (int i = 0; i < take_n; i++) begin
      do begin
        v = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom_range(7'h61, 7'h7a));
      end while (i > 0 && v == take_note[i-1]);
      take_note[i] = v;
      take_dur[i]  = $urandom_range(1, 4);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_buzz"}, buzz_note, 0);
    check_output({tag, "_play_note"}, play_note, 0);
    check_output({tag, "_recording"}, recording, 0);
    check_output({tag, "_playing"}, playing, 0);
    check_output({tag, "_slot_valid"}, slot_valid, 0);
    check_output({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    int slot, from;
    for (int s = 0; s < 3; s++) ev_cnt[s] = 0;
    exp_valid = 3'b000;
    exp_ovf = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    $display("[TB] directed take into slot 0");
    take_n = 2;
    take_note[0] = 7'h61; take_dur[0] = 3;
    take_note[1] = 7'h00; take_dur[1] = 2;
    record_take(0);
    play_take(0, 5, 8);

    $display("[TB] overflow take into slot 1");
    take_n = 5;
    for (int i = 0; i < 5; i++) begin
      take_note[i] = 7'(7'h63 + i);
      take_dur[i]  = (i % 2) + 1;
    end
    record_take(1);
    play_take(1, -1, -1);

    $display("[TB] ignored presses");
    slot_sel = 3'b011;
    press_button(1'b0);
    repeat (2) @(negedge clock);
    check_output("bad_sel_recording", recording, 0);
    check_output("bad_sel_slot_valid", slot_valid, exp_valid);
    slot_sel = 3'b100;
    press_button(1'b1);
    repeat (2) @(negedge clock);
    check_output("empty_slot_playing", playing, 0);

    $display("[TB] random takes");
    for (int t = 0; t < 4; t++) begin
      slot = $urandom_range(1, 2);
      random_take();
      record_take(slot);
      from = $urandom_range(0, 10);
      play_take(slot, from, from + $urandom_range(0, 4));
    end

    $display("[TB] abort playback");
    slot_sel = 3'b001;
    press_button(1'b1);
    repeat (6) @(negedge clock);
    press_button(1'b1);
    @(negedge clock);
    check_output("abort_playing", playing, 0);
    check_output("abort_note", play_note, 0);

    $display("[TB] reset during recording");
    key_code = 7'h61;
    press_button(1'b0);
    @(negedge clock);
    check_output("pre_reset_recording", recording, 1);
    resetn = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clock);
    resetn = 1'b1;
    key_code = 7'd0;
    for (int s = 0; s < 3; s++) ev_cnt[s] = 0;
    exp_valid = 3'b000;
    @(negedge clock);
    press_button(1'b1);
    repeat (2) @(negedge clock);
    check_output("post_reset_playing", playing, 0);
    check_output("post_reset_slot_valid", slot_valid, exp_valid);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
